// File: rtl/div_40_if.sv
// Operand/result bus of the sequential divider: an operand channel and a result channel.
// Both channels use valid/ready: a transfer happens on a rising edge where valid and ready are both
// high; the source holds valid and its payload stable until that edge, and ready never depends
// combinationally on valid.
interface div_40_if #(
    parameter int DW = 40,
    parameter int VW = 20
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          div_zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero
    );
endinterface

// File: rtl/div_40.sv
// Restoring unsigned divider, one quotient bit per cycle: DW-bit dividend by VW-bit divisor.
// Zero divisor short-circuits to an all-ones quotient with the dividend's low bits as remainder.
module div_40 #(
    parameter int DW = 40,
    parameter int VW = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    div_40_if.slave    bus,
    output logic [1:0] state_o
);
    localparam int CW = $clog2(DW);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e        state_q;
    logic [DW-1:0] shift_q;
    logic [DW-1:0] qacc_q;
    logic [VW-1:0] divisor_q;
    logic [VW-1:0] prem_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] quotient_q;
    logic [VW-1:0] remainder_q;
    logic          div_zero_q;

    logic [VW:0]   pr;
    logic          take;
    logic [VW-1:0] prem_d;
    logic [DW-1:0] qacc_d;

    // The stored remainder is always below the divisor, so VW bits suffice; only the trial value needs VW+1.
    always_comb begin
        pr     = {prem_q, shift_q[DW-1]};
        take   = (pr >= {1'b0, divisor_q});
        prem_d = take ? VW'(pr - {1'b0, divisor_q}) : pr[VW-1:0];
        qacc_d = {qacc_q[DW-2:0], take};
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            qacc_q      <= '0;
            divisor_q   <= '0;
            prem_q      <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        shift_q   <= bus.dividend;
                        divisor_q <= bus.divisor;
                        prem_q    <= '0;
                        qacc_q    <= '0;
                        cnt_q     <= '0;
                        if (bus.divisor == '0) begin
                            quotient_q  <= '1;
                            remainder_q <= bus.dividend[VW-1:0];
                            div_zero_q  <= 1'b1;
                            state_q     <= DONE;
                        end else begin
                            div_zero_q <= 1'b0;
                            state_q    <= CALC;
                        end
                    end
                end
                CALC: begin
                    shift_q <= shift_q << 1;
                    prem_q  <= prem_d;
                    qacc_q  <= qacc_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CW'(DW - 1)) begin
                        quotient_q  <= qacc_d;
                        remainder_q <= prem_d;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
    assign state_o       = state_q;
endmodule

// File: doc/div_40.md
# div_40

Sequential unsigned divider for the bicubic datapath: the inverse of the four-operand product stage. It takes a 40-bit product or weighted sum and divides it by a 20-bit normaliser, producing a 40-bit quotient and a 20-bit remainder. It uses a restoring, one-bit-per-cycle algorithm with valid/ready handshakes on both sides. It sits between the weight-multiply pipeline and the pixel output stage.

## Interface

- `DW`, default 40: dividend and quotient width.
- `VW`, default 20: divisor and remainder width.
- `clk` input 1: single clock; all logic updates on the rising edge.
- `rst_n` input 1: synchronous, active-high reset, keeping the codebase port name. While high at a rising edge, the block returns to IDLE.
- `in_valid` input 1: dividend/divisor offer valid.
- `in_ready` output 1: the block accepts an operand pair.
- `dividend` input DW: unsigned numerator.
- `divisor` input VW: unsigned denominator.
- `out_valid` output 1: result valid.
- `out_ready` input 1: downstream accepts the result.
- `quotient` output DW: unsigned quotient.
- `remainder` output VW: unsigned remainder.
- `div_zero` output 1: flags that the current result came from a zero divisor.

## Operation

- **States:** IDLE, CALC, DONE. All outputs are registered.
- **Reset:** state goes to IDLE. `out_valid`=0, `quotient`=0, `remainder`=0, `div_zero`=0, and the internal count is 0. `in_ready` is high in IDLE, so it is 1 one cycle after reset.
- **`in_ready`** = (state==IDLE). `in_valid` is ignored in CALC and DONE.
- **IDLE, on `in_valid`&&`in_ready`:**
  - Latch `dividend` into the shift register and `divisor` into the divisor register.
  - Clear the partial remainder (VW+1 bits) and set count=0.
  - If `divisor`==0, go to DONE with `quotient`=all ones, `remainder`=`dividend`[VW-1:0], `div_zero`=1.
  - Otherwise go to CALC with `div_zero`=0.
- **CALC, each cycle:**
  - Form pr = {partial_rem[VW-1:0], shift_reg MSB}, then shift the dividend register left by 1.
  - If pr >= divisor: partial_rem = pr - divisor and shift quotient bit 1 in at the LSB.
  - Otherwise: partial_rem = pr and shift quotient bit 0 in.
  - count increments each cycle. On the DW-th CALC cycle (count==DW-1), load `quotient`/`remainder` and go to DONE.
- **Width rule:** the partial remainder is VW+1 bits so the compare cannot overflow. The final remainder is always < `divisor` and fits in VW bits.
- **DONE:**
  - `out_valid`=1. `quotient`, `remainder` and `div_zero` are held stable while `out_ready`=0, for any length of backpressure.
  - On `out_valid`&&`out_ready`, go to IDLE and clear `out_valid`. Result registers keep their values until the next result loads.
- **No overlap:** a new operand cannot be accepted in the same cycle a result is consumed. The minimum gap between results is DW+2 cycles.
- **Reset mid-operation:** the in-flight division is discarded with no partial result emitted, and all reset values are restored.

## Timing

- **Accept:** the handshake completes at rising edge E0.
- **Normal divide:** `out_valid` rises after edge E0+DW, i.e. 40 cycles of CALC.
- **Divide by zero:** `out_valid` rises after edge E0+1.
- **Return to IDLE:** if `out_ready` is high when `out_valid` rises, `out_valid` is high for exactly one cycle, and `in_ready` rises on the following edge.
- **Combinational paths:** there are no combinational paths from inputs to outputs. `in_ready` and `out_valid` depend only on the state.

## Test plan

- **Bicubic product round-trip:** `dividend`=1095222947841 (1023^4), `divisor`=1046529 -> `quotient`=1046529, `remainder`=0, `div_zero`=0, with `out_valid` exactly 40 cycles after accept.
- **Small values and divisor larger than dividend:**
  - 100/7 -> `quotient`=14, `remainder`=2.
  - 3/1000 -> `quotient`=0, `remainder`=3.
  - 0xFF_FFFF_FFFF/1 -> `quotient`=0xFF_FFFF_FFFF, `remainder`=0.
  - 0xFF_FFFF_FFFF/0xF_FFFF -> `quotient`=0x10_0001, `remainder`=0.
- **Divide by zero:** 5/0 -> `quotient`=0xFF_FFFF_FFFF, `remainder`=5, `div_zero`=1, with `out_valid` one cycle after accept; the next normal divide shows `div_zero`=0.
- **Backpressure:**
  - Hold `out_ready`=0 for 10 cycles in DONE: outputs stay constant, `in_ready` stays 0, and `in_valid` pulses are ignored.
  - Raise `out_ready`: one transfer occurs, then `in_ready`=1 on the next cycle.
- **Reset mid-CALC:** assert `rst_n` high at CALC cycle 20 -> after the edge, state is IDLE, all outputs are 0 and no `out_valid` pulse appears. A following 100/7 returns 14 r 2.
- **Random regression:** 10k random pairs with nonzero divisor, with random `in_valid`/`out_ready` gaps -> quotient*divisor+remainder==dividend and remainder<divisor for every transfer, with results in order and none dropped or duplicated.
